jpc_fetch: RTL and testbench

JPC_FETCH -- requirements
Module: jpc_fetch

---
 rtl/jpc_pkg.sv | 18 +
 rtl/jpc_fetch_if.sv | 18 +
 rtl/jpc_config.v | 6 +
 rtl/jpc_fetch_fifo.sv | 58 +++++
 rtl/jpc_fetch.sv | 107 ++++++++++
 tb/tb_jpc_fetch.sv | 171 +++++++++++++++++
 6 files changed

// File: rtl/jpc_pkg.sv
// Shared types for the jpc fetch path: FSM state encoding and buffer entry.
`include "jpc_config.v"

package jpc_pkg;
  localparam int AW = `JPC_ADDRESS_WIDTH;
  localparam int IW = `JPC_INST_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/jpc_fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface jpc_fetch_if;
  logic                     imem_req_O;
  logic [jpc_pkg::AW-1:0]   imem_addr_O;
  logic                     imem_gnt_I;
  logic                     imem_rvalid_I;
  logic [jpc_pkg::IW-1:0]   imem_rdata_I;

  modport master (
    output imem_req_O, imem_addr_O,
    input  imem_gnt_I, imem_rvalid_I, imem_rdata_I
  );

  modport slave (
    input  imem_req_O, imem_addr_O,
    output imem_gnt_I, imem_rvalid_I, imem_rdata_I
  );
endinterface

// File: rtl/jpc_config.v
// Global widths shared by the jpc core blocks.
`ifndef JPC_CONFIG_V
`define JPC_CONFIG_V
`define JPC_ADDRESS_WIDTH 32
`define JPC_INST_WIDTH 32
`endif

// File: rtl/jpc_fetch_fifo.sv
// Synchronous instruction buffer: push/pop/flush with occupancy count.
// Flush wins over a same-cycle push or pop.
module jpc_fetch_fifo
  import jpc_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t data_o,
  output logic [CW-1:0] count_o
);
  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wptr_q] = data_i;
        wptr_d        = wptr_q + 1'b1;
      end
      if (pop_i) rptr_d = rptr_q + 1'b1;
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/jpc_fetch.sv
// Instruction fetch: one outstanding imem request, redirect/drop handling, decode buffer.
// Optional misaligned-PC fault when JPC_FETCH_ALIGN_CHECK_EN is defined.
`include "jpc_config.v"

module jpc_fetch
  import jpc_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [`JPC_ADDRESS_WIDTH-1:0] pc_I,
  output logic                          pc_en_O,
  output logic [`JPC_ADDRESS_WIDTH-1:0] next_pc_O,
  input  logic                          redirect_I,
  input  logic [`JPC_ADDRESS_WIDTH-1:0] redirect_pc_I,
  jpc_fetch_if.master                   imem,
  output logic                          inst_valid_O,
  output logic [`JPC_INST_WIDTH-1:0]    inst_O,
  output logic [`JPC_ADDRESS_WIDTH-1:0] inst_pc_O,
  input  logic                          dec_ready_I,
  output logic                          fault_O
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] req_pc_q, req_pc_d;
  logic [CW-1:0] count;
  fetch_entry_t  head, push_data;
  logic          misalign, req, gnt, push, pop;

`ifdef JPC_FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  assign misalign = (pc_I[1:0] != 2'b00);

  // Sticky until a redirect supplies a new (hopefully aligned) PC.
  always_comb begin
    fault_d = fault_q;
    if (redirect_I)                              fault_d = 1'b0;
    else if (state_q == ST_IDLE && misalign)     fault_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end

  assign fault_O = fault_q;
`else
  assign misalign = 1'b0;
  assign fault_O  = 1'b0;
`endif

  always_comb begin
    req = !rst && (state_q == ST_IDLE) && !redirect_I && !fault_O && !misalign &&
          (count < CW'(FIFO_DEPTH));
    gnt  = req && imem.imem_gnt_I;
    push = (state_q == ST_WAIT) && imem.imem_rvalid_I && !redirect_I;
    pop  = inst_valid_O && dec_ready_I;

    state_d  = state_q;
    req_pc_d = req_pc_q;
    case (state_q)
      ST_IDLE: if (gnt) begin
        state_d  = ST_WAIT;
        req_pc_d = pc_I;
      end
      // A response that lands with a redirect is stale; just return to idle.
      ST_WAIT: if (imem.imem_rvalid_I) state_d = ST_IDLE;
               else if (redirect_I)    state_d = ST_DROP;
      ST_DROP: if (imem.imem_rvalid_I) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign push_data = '{pc: req_pc_q, inst: imem.imem_rdata_I};

  jpc_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .flush_i (redirect_I),
    .data_o  (head),
    .count_o (count)
  );

  assign imem.imem_req_O  = req;
  assign imem.imem_addr_O = pc_I;
  assign pc_en_O          = !rst && (redirect_I || gnt);
  assign next_pc_O        = redirect_I ? redirect_pc_I : pc_I + AW'(4);
  assign inst_valid_O     = (count != '0);
  assign inst_O           = head.inst;
  assign inst_pc_O        = head.pc;
endmodule

// File: tb/tb_jpc_fetch.sv
// Directed vector bench for jpc_fetch (FIFO_DEPTH=2, 32-bit addresses).
module tb_jpc_fetch;
  import jpc_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc, next_pc, redirect_pc, inst_pc;
  logic          pc_en, redirect, inst_valid, dec_ready, fault;
  logic [IW-1:0] inst;
  int            n_cmp = 0;
  int            n_bad = 0;

  jpc_fetch_if imem_if ();

  jpc_fetch #(.FIFO_DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_I          (pc),
    .pc_en_O       (pc_en),
    .next_pc_O     (next_pc),
    .redirect_I    (redirect),
    .redirect_pc_I (redirect_pc),
    .imem          (imem_if),
    .inst_valid_O  (inst_valid),
    .inst_O        (inst),
    .inst_pc_O     (inst_pc),
    .dec_ready_I   (dec_ready),
    .fault_O       (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        redir;
    logic [31:0] rpc;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        e_pcen;
    logic [31:0] e_npc;
    logic        e_req, e_iv;
    logic [31:0] e_inst, e_ipc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [31:0] p, logic rd, logic [31:0] rp, logic g, logic r,
                              logic [31:0] dat, logic rdy, logic pe, logic [31:0] np,
                              logic rq, logic iv, logic [31:0] ei, logic [31:0] ep);
    vec_t v;
    v.pc = p; v.redir = rd; v.rpc = rp; v.gnt = g; v.rv = r; v.rdata = dat; v.rdy = rdy;
    v.e_pcen = pe; v.e_npc = np; v.e_req = rq; v.e_iv = iv; v.e_inst = ei; v.e_ipc = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p, input logic rd, input logic [31:0] rp,
                       input logic g, input logic r, input logic [31:0] dat, input logic rdy);
    pc = p; redirect = rd; redirect_pc = rp;
    imem_if.imem_gnt_I = g; imem_if.imem_rvalid_I = r; imem_if.imem_rdata_I = dat;
    dec_ready = rdy;
  endtask

  initial begin
    //            pc          rd rpc        g  rv rdata        rdy  pcen npc         req iv inst          ipc
    tbl.push_back(mk(32'h0,   0, 0,         1, 0, 0,            1,  1, 32'h4,       1, 0, 0,            0));
    tbl.push_back(mk(32'h4,   0, 0,         1, 1, 32'h00500093, 1,  0, 32'h8,       0, 0, 0,            0));
    tbl.push_back(mk(32'h4,   0, 0,         0, 0, 0,            1,  0, 32'h8,       1, 1, 32'h00500093, 32'h0));
    tbl.push_back(mk(32'h4,   0, 0,         1, 0, 0,            0,  1, 32'h8,       1, 0, 0,            0));
    tbl.push_back(mk(32'h8,   0, 0,         0, 1, 32'h11111111, 0,  0, 32'hC,       0, 0, 0,            0));
    tbl.push_back(mk(32'h8,   0, 0,         1, 0, 0,            0,  1, 32'hC,       1, 1, 32'h11111111, 32'h4));
    tbl.push_back(mk(32'hC,   0, 0,         0, 1, 32'h22222222, 0,  0, 32'h10,      0, 1, 32'h11111111, 32'h4));
    tbl.push_back(mk(32'hC,   0, 0,         1, 0, 0,            0,  0, 32'h10,      0, 1, 32'h11111111, 32'h4));
    tbl.push_back(mk(32'hC,   0, 0,         0, 0, 0,            1,  0, 32'h10,      0, 1, 32'h11111111, 32'h4));
    tbl.push_back(mk(32'hC,   0, 0,         0, 0, 0,            0,  0, 32'h10,      1, 1, 32'h22222222, 32'h8));
    tbl.push_back(mk(32'hC,   0, 0,         0, 0, 0,            1,  0, 32'h10,      1, 1, 32'h22222222, 32'h8));
    // redirect while waiting: the late response is dropped
    tbl.push_back(mk(32'hC,   0, 0,         1, 0, 0,            1,  1, 32'h10,      1, 0, 0,            0));
    tbl.push_back(mk(32'h10,  1, 32'h100,   0, 0, 0,            1,  1, 32'h100,     0, 0, 0,            0));
    tbl.push_back(mk(32'h100, 0, 0,         0, 1, 32'hDEADBEEF, 1,  0, 32'h104,     0, 0, 0,            0));
    tbl.push_back(mk(32'h100, 0, 0,         0, 0, 0,            1,  0, 32'h104,     1, 0, 0,            0));
    // redirect and response in the same WAIT cycle
    tbl.push_back(mk(32'h100, 0, 0,         1, 0, 0,            1,  1, 32'h104,     1, 0, 0,            0));
    tbl.push_back(mk(32'h104, 1, 32'h100,   0, 1, 32'hCAFEF00D, 1,  1, 32'h100,     0, 0, 0,            0));
    tbl.push_back(mk(32'h100, 0, 0,         0, 0, 0,            1,  0, 32'h104,     1, 0, 0,            0));
    // stray response in IDLE
    tbl.push_back(mk(32'h100, 0, 0,         0, 1, 32'h12345678, 1,  0, 32'h104,     1, 0, 0,            0));
    tbl.push_back(mk(32'h100, 0, 0,         0, 0, 0,            1,  0, 32'h104,     1, 0, 0,            0));
    // redirect beats grant in IDLE
    tbl.push_back(mk(32'h100, 1, 32'h40,    1, 0, 0,            1,  1, 32'h40,      0, 0, 0,            0));
    tbl.push_back(mk(32'h40,  0, 0,         1, 0, 0,            0,  1, 32'h44,      1, 0, 0,            0));
    tbl.push_back(mk(32'h44,  0, 0,         0, 1, 32'hAAAA0001, 0,  0, 32'h48,      0, 0, 0,            0));
    tbl.push_back(mk(32'h44,  1, 32'h80,    0, 0, 0,            0,  1, 32'h80,      0, 1, 32'hAAAA0001, 32'h40));
    tbl.push_back(mk(32'h80,  0, 0,         0, 0, 0,            0,  0, 32'h84,      1, 0, 0,            0));
    // next-PC wraps at the top of the address space
    tbl.push_back(mk(32'hFFFFFFFC, 0, 0,    1, 0, 0,            1,  1, 32'h0,       1, 0, 0,            0));
    tbl.push_back(mk(32'h0,   0, 0,         0, 1, 32'h0BADF00D, 1,  0, 32'h4,       0, 0, 0,            0));
    tbl.push_back(mk(32'h0,   0, 0,         0, 0, 0,            1,  0, 32'h4,       1, 1, 32'h0BADF00D, 32'hFFFFFFFC));

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req", imem_if.imem_req_O, 0);
    chk("rst pc_en", pc_en, 0);
    chk("rst inst_valid", inst_valid, 0);
    chk("rst fault", fault, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = 1'b0;
      drive(tbl[i].pc, tbl[i].redir, tbl[i].rpc, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].rdy);
      #1;
      chk($sformatf("v%0d pc_en", i), pc_en, tbl[i].e_pcen);
      chk($sformatf("v%0d next_pc", i), next_pc, tbl[i].e_npc);
      chk($sformatf("v%0d req", i), imem_if.imem_req_O, tbl[i].e_req);
      chk($sformatf("v%0d addr", i), imem_if.imem_addr_O, tbl[i].pc);
      chk($sformatf("v%0d inst_valid", i), inst_valid, tbl[i].e_iv);
      chk($sformatf("v%0d fault", i), fault, 0);
      if (tbl[i].e_iv) begin
        chk($sformatf("v%0d inst", i), inst, tbl[i].e_inst);
        chk($sformatf("v%0d inst_pc", i), inst_pc, tbl[i].e_ipc);
      end
    end

    // reset while a request is outstanding; its response must be ignored
    @(negedge clk); drive(32'h0, 0, 0, 1, 0, 0, 1); #1;
    chk("rw req", imem_if.imem_req_O, 1);
    @(negedge clk); rst = 1'b1; drive(32'h4, 0, 0, 0, 0, 0, 1); #1;
    chk("rw rst req", imem_if.imem_req_O, 0);
    chk("rw rst pc_en", pc_en, 0);
    @(negedge clk); rst = 1'b0; drive(32'h4, 0, 0, 0, 1, 32'h55, 1); #1;
    chk("rw idle req", imem_if.imem_req_O, 1);
    @(negedge clk); drive(32'h4, 0, 0, 0, 0, 0, 1); #1;
    chk("rw inst_valid", inst_valid, 0);

`ifdef JPC_FETCH_ALIGN_CHECK_EN
    @(negedge clk); drive(32'h102, 0, 0, 1, 0, 0, 1); #1;
    chk("al req0", imem_if.imem_req_O, 0);
    chk("al fault0", fault, 0);
    @(negedge clk); #1;
    chk("al fault1", fault, 1);
    chk("al req1", imem_if.imem_req_O, 0);
    chk("al pc_en1", pc_en, 0);
    @(negedge clk); drive(32'h102, 1, 32'h200, 0, 0, 0, 1); #1;
    chk("al redir pc_en", pc_en, 1);
    chk("al redir npc", next_pc, 32'h200);
    @(negedge clk); drive(32'h200, 0, 0, 0, 0, 0, 1); #1;
    chk("al clr fault", fault, 0);
    chk("al clr req", imem_if.imem_req_O, 1);
    chk("al clr addr", imem_if.imem_addr_O, 32'h200);
`else
    @(negedge clk); drive(32'h102, 0, 0, 0, 0, 0, 1); #1;
    chk("na req", imem_if.imem_req_O, 1);
    chk("na addr", imem_if.imem_addr_O, 32'h102);
    @(negedge clk); #1;
    chk("na fault", fault, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
